// File: rtl/result_uart_tx_pkg.sv
// result_uart_tx_pkg: FSM encoding and frame constants shared by result_uart_tx and its bench.
package result_uart_tx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam int DATA_BITS = 8;
`ifdef RESULT_UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif
    function automatic int frame_cycles(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction
endpackage

// File: rtl/result_uart_tx_fifo.sv
// result_fifo: synchronous FIFO; a push into a full FIFO is still accepted when a pop happens in the same cycle.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0] cnt_t;
    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == cnt_t'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop) rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers multiplier result bytes and sends them LSB-first as 8N1 UART frames.
// Define RESULT_UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      res_data,
    input  logic                            res_valid,
    output logic                            tx_serial,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef logic [BW-1:0] baud_t;
    state_t state;
    baud_t baud_cnt;
    logic [2:0] bit_idx;
    logic [DATA_BITS-1:0] tx_byte, fifo_dout;
    logic fifo_empty, fifo_full, pop, last_tick;
    assign last_tick = baud_cnt == baud_t'(CLKS_PER_BIT - 1);
    // The FIFO is only read from IDLE or on the final stop-bit cycle, so frames chain with no gap.
    assign pop       = !fifo_empty && (state == IDLE || (state == STOP && last_tick));
    assign tx_busy   = state != IDLE;
    result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_valid),
        .pop   (pop),
        .din   (res_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_byte   <= '0;
            tx_serial <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            overflow <= overflow | (res_valid & fifo_full & ~pop);
            baud_cnt <= (state == IDLE || last_tick) ? '0 : baud_cnt + baud_t'(1);
            if (pop) tx_byte <= fifo_dout;
            case (state)
                IDLE: if (pop) begin
                    state     <= START;
                    tx_serial <= 1'b0;
                end
                START: if (last_tick) begin
                    state     <= DATA;
                    bit_idx   <= '0;
                    tx_serial <= tx_byte[0];
                end
                DATA: if (last_tick) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
                        state     <= PARITY;
                        tx_serial <= ^tx_byte;
`else
                        state     <= STOP;
                        tx_serial <= 1'b1;
`endif
                    end else begin
                        tx_serial <= tx_byte[bit_idx + 3'd1];
                    end
                end
`ifdef RESULT_UART_TX_PARITY_EN
                PARITY: if (last_tick) begin
                    state     <= STOP;
                    tx_serial <= 1'b1;
                end
`endif
                STOP: if (last_tick) begin
                    state     <= pop ? START : IDLE;
                    tx_serial <= !pop;
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed self-checking bench for result_uart_tx (8N1, or 8E1 with RESULT_UART_TX_PARITY_EN).
`timescale 1ns/1ps
module tb_result_uart_tx;
    import result_uart_tx_pkg::*;
    localparam int CPB = 10;
    localparam int FL  = FRAME_BITS * CPB;
    localparam int CAP = 700;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic res_valid = 1'b0;
    logic [7:0] res_data = 8'h00;
    logic tx_serial, tx_busy, overflow;
    logic [2:0] fifo_count;
    logic cap_line [CAP];
    logic cap_busy [CAP];
    int peak = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (int'(fifo_count) > peak) peak = int'(fifo_count);

    result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        res_data  = d;
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < CAP; i++) begin
            cap_line[i] = 1'b1;
            cap_busy[i] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            step();
            cap_line[i] = tx_serial;
            cap_busy[i] = tx_busy;
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef RESULT_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input int base, input logic [7:0] b, input string tag);
        for (int k = 0; k < FRAME_BITS; k++)
            chk($sformatf("%s_bit%0d", tag, k), 32'(cap_line[base + k*CPB + CPB/2]), 32'(frame_bit(b, k)));
    endtask

    function automatic int busy_len();
        int n = 0;
        while (n < CAP && cap_busy[n]) n++;
        return n;
    endfunction

    initial begin
        #12;
        chk("rst_serial", 32'(tx_serial), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        // single byte from idle: line falls right after the pop edge
        push(8'hA5);
        chk("a5_count_after_push", 32'(fifo_count), 32'd1);
        capture(FL + 20);
        chk("a5_fall_e1", 32'(cap_line[0]), 32'd0);
        check_frame(0, 8'hA5, "a5");
        chk("a5_busy_len", 32'(busy_len()), 32'(FL));
        chk("a5_idle_after", 32'(cap_line[FL + 5]), 32'd1);
        chk("a5_count_end", 32'(fifo_count), 32'd0);

        // four-byte burst: capture starts 3 cycles into the first frame
        peak = 0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        capture(4*FL + 20);
        chk("burst_busy_len", 32'(busy_len()), 32'(4*FL - 3));
        check_frame(-3, 8'h11, "burst0");
        check_frame(-3 + FL, 8'h22, "burst1");
        check_frame(-3 + 2*FL, 8'h33, "burst2");
        check_frame(-3 + 3*FL, 8'h44, "burst3");
        chk("burst_peak", 32'(peak), 32'd3);
        chk("burst_overflow", 32'(overflow), 32'd0);

        // six writes: the sixth is dropped
        peak = 0;
        for (int i = 1; i <= 6; i++) push(8'(i));
        chk("six_overflow", 32'(overflow), 32'd1);
        chk("six_count", 32'(fifo_count), 32'd4);
        capture(5*FL + 20);
        chk("six_busy_len", 32'(busy_len()), 32'(5*FL - 5));
        for (int i = 0; i < 5; i++) check_frame(-5 + i*FL, 8'(i + 1), $sformatf("six%0d", i));
        chk("six_peak", 32'(peak), 32'd4);
        chk("six_count_end", 32'(fifo_count), 32'd0);

        // write coinciding with the last stop cycle while full
        pulse_reset();
        chk("rst2_overflow", 32'(overflow), 32'd0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        push(8'hA5);
        chk("full_count", 32'(fifo_count), 32'd4);
        repeat (FL - 4) step();
        chk("full_last_stop_line", 32'(tx_serial), 32'd1);
        push(8'hB6);
        chk("bypass_count", 32'(fifo_count), 32'd4);
        chk("bypass_overflow", 32'(overflow), 32'd0);
        chk("bypass_next_start", 32'(tx_serial), 32'd0);
        capture(5*FL + 10);
        chk("bypass_busy_len", 32'(busy_len()), 32'(5*FL - 1));
        check_frame(-1, 8'hA2, "bypass_a2");
        check_frame(-1 + 4*FL, 8'hB6, "bypass_b6");

        // reset in the middle of data bit 3
        pulse_reset();
        push(8'h5A);
        push(8'h77);
        repeat (45) step();
        chk("mid_bit3_line", 32'(tx_serial), 32'(frame_bit(8'h5A, 4)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(tx_serial), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        push(8'h3C);
        capture(FL + 20);
        check_frame(0, 8'h3C, "post_rst_3c");
        chk("post_rst_busy_len", 32'(busy_len()), 32'(FL));

`ifdef RESULT_UART_TX_PARITY_EN
        push(8'h07);
        capture(FL + 20);
        chk("par07_bit", 32'(cap_line[9*CPB + 5]), 32'd1);
        chk("par07_len", 32'(busy_len()), 32'd110);
        check_frame(0, 8'h07, "par07");
        push(8'h03);
        capture(FL + 20);
        chk("par03_bit", 32'(cap_line[9*CPB + 5]), 32'd0);
        chk("par03_len", 32'(busy_len()), 32'd110);
`else
        chk("frame_len_8n1", 32'(FL), 32'(frame_cycles(CPB)));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
